usb_upload_frame_tx: RTL and testbench
======================================

Name: usb_upload_frame_tx

Overview:
Frame transmitter for the USB CDC upload path, the opposite direction of the command parser that decodes host frames. A capture or measurement block requests a frame with a command code and payload length, then streams its payload bytes. The block wraps them as header, cmd, length, payload and checksum, and drives the usb_upload_data/usb_upload_valid byte stream toward USB_CDC. It runs in the PHY_CLK (60 MHz) domain.

Parameters:
HDR0, 8'hAA, first sync byte
HDR1, 8'h44, second sync byte
MAX_LEN, 4096, largest accepted payload length in bytes (range 1..65535)

Ports:
clk  input  1  PHY_CLK domain clock
rst  input  1  synchronous reset, active-high
start  input  1  frame request pulse; sampled only in IDLE
start_cmd  input  8  command code, captured on an accepted start
start_len  input  16  payload byte count, captured on an accepted start
start_ack  output  1  one-cycle pulse: request accepted
len_err  output  1  one-cycle pulse: request rejected because start_len > MAX_LEN
pl_data  input  8  payload byte
pl_valid  input  1  payload byte valid
pl_ready  output  1  payload byte accepted when pl_valid && pl_ready
usb_upload_data  output  8  frame byte to USB_CDC
usb_upload_valid  output  1  frame byte valid
usb_upload_ready  input  1  USB side accepts the byte when valid && ready
busy  output  1  high from an accepted start until the checksum byte is accepted
frame_done  output  1  one-cycle pulse on the cycle the checksum byte is accepted

Behaviour:
- Reset: state=IDLE. usb_upload_valid, usb_upload_data, pl_ready, start_ack, len_err, busy, frame_done, checksum, byte counter and captured cmd/len are all 0. Reset asserted mid-frame aborts the frame at once; no trailing bytes are sent.
- Output register: one data/valid register. It loads a new byte when (!usb_upload_valid || usb_upload_ready) and a byte is available. Data must not change while valid && !ready (AXI-stream rules). Valid drops when the register empties and no new byte is available.
- States: IDLE -> HDR0 -> HDR1 -> CMD -> LENH -> LENL -> PAYLOAD -> CSUM -> IDLE. Each state emits one byte and advances when that byte loads into the output register.
- IDLE:
  - start && start_len <= MAX_LEN: capture cmd/len, pulse start_ack, set busy, go to HDR0.
  - start && start_len > MAX_LEN: pulse len_err and stay in IDLE.
  - start while not IDLE: ignored, no ack and no err.
- Latency: start accepted at cycle N gives usb_upload_valid=1 with data HDR0 at N+1. With ready held high, one byte goes out per cycle, so a frame takes len+6 cycles.
- Byte values, in order:
  - HDR0, HDR1, cmd, len[15:8], len[7:0].
  - Payload bytes.
  - Checksum = 8-bit sum, mod 256, of cmd, len_hi, len_lo and every payload byte. Sync bytes are excluded.
- LENL with len==0: go straight to CSUM; pl_ready never asserts.
- PAYLOAD:
  - pl_ready = (!usb_upload_valid || usb_upload_ready), combinational.
  - A pl handshake loads the output register the same cycle, so the payload path adds no buffering and has one cycle of latency.
  - The byte counter decrements on each handshake; after the last byte, go to CSUM.
  - pl_valid low inserts bubbles (usb_upload_valid=0); this is legal.
- pl_ready is 0 in all states other than PAYLOAD. pl_valid outside PAYLOAD is ignored and the data is not consumed.
- CSUM: load the checksum. frame_done pulses and busy falls when the checksum is accepted (valid && ready). The state returns to IDLE at that point, so a start on the next cycle is accepted (back-to-back frames).
- Checksum and counter reset on each accepted start.

Test Plan:
- cmd=0x0B, len=3, payload 01 02 03, ready=1 -> stream AA 44 0B 00 03 01 02 03 14. First byte at start+1; frame_done on the cycle 0x14 is accepted.
- cmd=0x20, len=0 -> stream AA 44 20 00 00 20; pl_ready never high.
- len=4 payload FF FF FF FF, cmd=0xFF -> checksum wraps: (FF+00+04+4*FF) mod 256 = 0xFF.
- Random ready deassertion (≥30% duty) during the len=3 frame -> data stable while valid&&!ready; same 9 bytes, no loss or duplication.
- start_len=MAX_LEN+1 -> len_err pulse, no start_ack, busy=0, no output. A start during busy -> ignored, frame unaffected.
- rst asserted mid-PAYLOAD -> next cycle valid=0, busy=0, state IDLE. A new start then produces a correct full frame.

Source files
------------

// File: rtl/usb_upload_frame_tx_if.sv
// Handshake bundle between the upload frame transmitter and its neighbours:
// frame request, payload stream in, and framed byte stream out toward USB_CDC.
interface usb_upload_frame_tx_if;
  logic        start;
  logic [7:0]  start_cmd;
  logic [15:0] start_len;
  logic        start_ack;
  logic        len_err;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  usb_upload_data;
  logic        usb_upload_valid;
  logic        usb_upload_ready;
  logic        busy;
  logic        frame_done;

  modport slave (
    input  start, start_cmd, start_len, pl_data, pl_valid, usb_upload_ready,
    output start_ack, len_err, pl_ready, usb_upload_data, usb_upload_valid, busy, frame_done
  );

  modport master (
    output start, start_cmd, start_len, pl_data, pl_valid, usb_upload_ready,
    input  start_ack, len_err, pl_ready, usb_upload_data, usb_upload_valid, busy, frame_done
  );
endinterface

// File: rtl/usb_upload_frame_tx.sv
// Upload frame transmitter: wraps a payload as HDR0 HDR1 cmd len_hi len_lo payload csum
// and streams it through a single data/valid output register (PHY_CLK domain).
module usb_upload_frame_tx #(
  parameter logic [7:0]  HDR0    = 8'hAA,
  parameter logic [7:0]  HDR1    = 8'h44,
  parameter int unsigned MAX_LEN = 4096
) (
  input logic                  clk,
  input logic                  rst,
  usb_upload_frame_tx_if.slave bus
);

  // HDR0 is loaded straight from IDLE on acceptance so the first byte is
  // valid the cycle after start; the remaining states each emit one byte.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_CMD,
    ST_LENH,
    ST_LENL,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [7:0]  csum_q;
  logic        csum_loaded_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ack_q;
  logic        err_q;

  logic        len_ok;
  logic        accept;
  logic        reject;
  logic        slot_free;
  logic        byte_avail;
  logic [7:0]  byte_val;
  logic        add_to_sum;
  logic        load;
  logic        csum_taken;
  logic        pl_ready_c;

  assign len_ok    = ({1'b0, bus.start_len} <= MAX_LEN_W);
  assign accept    = (state_q == ST_IDLE) && bus.start && len_ok;
  assign reject    = (state_q == ST_IDLE) && bus.start && !len_ok;
  assign slot_free = !valid_q || bus.usb_upload_ready;
  assign load      = byte_avail && slot_free;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = ST_HDR1;
      ST_HDR1:    if (load) state_d = ST_CMD;
      ST_CMD:     if (load) state_d = ST_LENH;
      ST_LENH:    if (load) state_d = ST_LENL;
      ST_LENL:    if (load) state_d = (len_q == 16'd0) ? ST_CSUM : ST_PAYLOAD;
      ST_PAYLOAD: if (load && cnt_q == 16'd1) state_d = ST_CSUM;
      ST_CSUM:    if (csum_taken) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output/byte-source logic.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_avail = 1'b0;
    byte_val   = 8'h00;
    add_to_sum = 1'b0;
    pl_ready_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        byte_avail = accept;
        byte_val   = HDR0;
      end
      ST_HDR1: begin
        byte_avail = 1'b1;
        byte_val   = HDR1;
      end
      ST_CMD: begin
        byte_avail = 1'b1;
        byte_val   = cmd_q;
        add_to_sum = 1'b1;
      end
      ST_LENH: begin
        byte_avail = 1'b1;
        byte_val   = len_q[15:8];
        add_to_sum = 1'b1;
      end
      ST_LENL: begin
        byte_avail = 1'b1;
        byte_val   = len_q[7:0];
        add_to_sum = 1'b1;
      end
      ST_PAYLOAD: begin
        pl_ready_c = slot_free;
        byte_avail = bus.pl_valid;
        byte_val   = bus.pl_data;
        add_to_sum = 1'b1;
      end
      ST_CSUM: begin
        byte_avail = !csum_loaded_q;
        byte_val   = csum_q;
      end
      default: ;
    endcase
  end

  // Once the checksum sits in the output register, its handshake ends the frame.
  assign csum_taken = (state_q == ST_CSUM) && csum_loaded_q && valid_q && bus.usb_upload_ready;

  // Datapath: output register, captured request, checksum and byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q         <= 8'h00;
      len_q         <= 16'h0000;
      cnt_q         <= 16'h0000;
      csum_q        <= 8'h00;
      csum_loaded_q <= 1'b0;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      ack_q <= accept;
      err_q <= reject;

      if (load) begin
        data_q  <= byte_val;
        valid_q <= 1'b1;
      end else if (bus.usb_upload_ready) begin
        valid_q <= 1'b0;
      end

      if (accept) begin
        cmd_q         <= bus.start_cmd;
        len_q         <= bus.start_len;
        cnt_q         <= bus.start_len;
        csum_q        <= 8'h00;
        csum_loaded_q <= 1'b0;
      end else if (load) begin
        if (add_to_sum) csum_q <= csum_q + byte_val;
        if (state_q == ST_PAYLOAD) cnt_q <= cnt_q - 16'd1;
        if (state_q == ST_CSUM) csum_loaded_q <= 1'b1;
      end
    end
  end

  assign bus.usb_upload_data  = data_q;
  assign bus.usb_upload_valid = valid_q;
  assign bus.pl_ready         = pl_ready_c;
  assign bus.start_ack        = ack_q;
  assign bus.len_err          = err_q;
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.frame_done       = csum_taken;

endmodule

// File: tb/tb_usb_upload_frame_tx.sv
// Scoreboard bench for usb_upload_frame_tx: each frame's expected byte stream is
// built from the framing rules and a separate monitor checks every accepted byte.
module tb_usb_upload_frame_tx;
  localparam int MAX_LEN = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_upload_frame_tx_if bus();

  usb_upload_frame_tx #(
    .HDR0   (8'hAA),
    .HDR1   (8'h44),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] data;
    bit         last;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pay[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc = 0;
  int pl_ready_hits = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected bytes on each output handshake, and checks that a
  // stalled byte stays put until it is taken.
  initial begin : monitor
    bit         held;
    logic [7:0] held_data;
    exp_t       e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (bus.pl_ready) pl_ready_hits++;
      if (held) begin
        check("stall_valid", bus.usb_upload_valid, 1);
        check("stall_data", bus.usb_upload_data, held_data);
      end
      if (bus.usb_upload_valid && bus.usb_upload_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", bus.usb_upload_data);
        end else begin
          e = sb.pop_front();
          check("stream_byte", bus.usb_upload_data, e.data);
          check("frame_done", bus.frame_done, e.last);
          if (e.last) done_cyc = cyc;
        end
      end else begin
        check("frame_done_idle", bus.frame_done, 0);
      end
      held      = bus.usb_upload_valid && !bus.usb_upload_ready;
      held_data = bus.usb_upload_data;
    end
  end

  // Output-side backpressure: either always ready or ~40% stalls.
  initial begin : ready_drv
    bus.usb_upload_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.usb_upload_ready = rand_ready ? ($urandom_range(99) >= 40) : 1'b1;
    end
  end

  // Issues one frame request using the payload held in pay[]. abort_at >= 0
  // asserts rst once that many payload bytes have been handed over.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [15:0] len,
                           input bit bubbles, input bit poke_busy, input int abort_at);
    int   s;
    int   idx;
    int   guard;
    int   start_cyc;
    bit   hs;
    bit   poked;
    exp_t e;

    // Reference frame: sync bytes, cmd, length, payload, sum of the non-sync bytes mod 256.
    s = int'(cmd) + int'(len[15:8]) + int'(len[7:0]);
    e.last = 1'b0;
    e.data = 8'hAA; sb.push_back(e);
    e.data = 8'h44; sb.push_back(e);
    e.data = cmd;   sb.push_back(e);
    e.data = len[15:8]; sb.push_back(e);
    e.data = len[7:0];  sb.push_back(e);
    for (int i = 0; i < int'(len); i++) begin
      e.data = pay[i];
      sb.push_back(e);
      s += int'(pay[i]);
    end
    e.data = 8'(s % 256);
    e.last = 1'b1;
    sb.push_back(e);

    done_cyc      = 0;
    pl_ready_hits = 0;
    bus.start     = 1'b1;
    bus.start_cmd = cmd;
    bus.start_len = len;
    start_cyc     = cyc + 1;
    tick();
    bus.start = 1'b0;
    check({tag, "_start_ack"}, bus.start_ack, 1);
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_first_valid"}, bus.usb_upload_valid, 1);
    check({tag, "_first_data"}, bus.usb_upload_data, 8'hAA);

    idx   = 0;
    guard = 0;
    poked = 1'b0;
    while (idx < int'(len) && guard < 6000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        bus.pl_valid = 1'b0;
        rst = 1'b1;
        tick();
        sb.delete();
        check({tag, "_abort_valid"}, bus.usb_upload_valid, 0);
        check({tag, "_abort_busy"}, bus.busy, 0);
        check({tag, "_abort_pl_ready"}, bus.pl_ready, 0);
        rst = 1'b0;
        tick();
        check({tag, "_abort_quiet"}, bus.usb_upload_valid, 0);
        return;
      end
      bus.pl_valid = bubbles ? ($urandom_range(3) != 0) : 1'b1;
      bus.pl_data  = pay[idx];
      if (poke_busy && idx == 1 && !poked) begin
        bus.start     = 1'b1;
        bus.start_cmd = 8'h55;
        bus.start_len = 16'd1;
        poked         = 1'b1;
      end
      @(negedge clk);
      hs = bus.pl_valid && bus.pl_ready;
      tick();
      if (bus.start) begin
        bus.start = 1'b0;
        check({tag, "_busy_start_ack"}, bus.start_ack, 0);
        check({tag, "_busy_start_err"}, bus.len_err, 0);
      end
      if (hs) idx++;
      guard++;
    end
    bus.pl_valid = 1'b0;
    if (idx < int'(len)) begin
      tests++;
      fails++;
      $display("FAIL %s_payload_timeout: got %0d bytes expected %0d", tag, idx, len);
    end

    guard = 0;
    while (bus.busy && guard < 6000) begin
      tick();
      guard++;
    end
    check({tag, "_busy_cleared"}, bus.busy, 0);
    check({tag, "_sb_drained"}, sb.size(), 0);
    if (sb.size() != 0) sb.delete();
    if (!bubbles && !rand_ready)
      check({tag, "_frame_cycles"}, done_cyc - start_cyc, int'(len) + 6);
    if (len == 16'd0) check({tag, "_pl_ready_never"}, pl_ready_hits, 0);
  endtask

  task automatic fill_random(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(255)));
  endtask

  initial begin : main
    int len;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.start_cmd = 8'h00;
    bus.start_len = 16'h0000;
    bus.pl_data   = 8'h00;
    bus.pl_valid  = 1'b0;
    repeat (3) tick();
    check("rst_valid", bus.usb_upload_valid, 0);
    check("rst_data", bus.usb_upload_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pl_ready", bus.pl_ready, 0);
    check("rst_start_ack", bus.start_ack, 0);
    check("rst_len_err", bus.len_err, 0);
    check("rst_frame_done", bus.frame_done, 0);
    rst = 1'b0;
    tick();

    pay = '{8'h01, 8'h02, 8'h03};
    run_frame("basic", 8'h0B, 16'd3, 1'b0, 1'b0, -1);

    pay.delete();
    run_frame("len0", 8'h20, 16'd0, 1'b0, 1'b0, -1);

    pay = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame("wrap", 8'hFF, 16'd4, 1'b0, 1'b0, -1);

    rand_ready = 1'b1;
    pay = '{8'h01, 8'h02, 8'h03};
    run_frame("stall", 8'h0B, 16'd3, 1'b0, 1'b0, -1);
    rand_ready = 1'b0;
    tick();

    bus.start     = 1'b1;
    bus.start_cmd = 8'h01;
    bus.start_len = 16'(MAX_LEN + 1);
    tick();
    bus.start = 1'b0;
    check("lenerr_pulse", bus.len_err, 1);
    check("lenerr_no_ack", bus.start_ack, 0);
    check("lenerr_busy", bus.busy, 0);
    check("lenerr_valid", bus.usb_upload_valid, 0);
    tick();
    check("lenerr_one_cycle", bus.len_err, 0);
    check("lenerr_quiet", bus.usb_upload_valid, 0);

    fill_random(5);
    run_frame("busy_poke", 8'h3C, 16'd5, 1'b0, 1'b1, -1);

    for (int f = 0; f < 8; f++) begin
      len        = $urandom_range(24);
      rand_ready = $urandom_range(1);
      fill_random(len);
      run_frame("rand", 8'($urandom_range(255)), 16'(len), 1'($urandom_range(1)), 1'b0, -1);
    end
    rand_ready = 1'b0;
    tick();

    fill_random(10);
    run_frame("abort", 8'h33, 16'd10, 1'b0, 1'b0, 4);

    pay = '{8'h01, 8'h02, 8'h03};
    run_frame("post_rst", 8'h0B, 16'd3, 1'b0, 1'b0, -1);

    fill_random(MAX_LEN);
    run_frame("max_len", 8'h7E, 16'(MAX_LEN), 1'b0, 1'b0, -1);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
